// File: rtl/parallel_to_serial.sv
// Parallel-to-serial converter: valid/ready word input buffered in a small FIFO,
// emitted LSB first one bit per cycle with zero-bubble streaming between words.
module parallel_to_serial #(
   parameter int width = 8,
   parameter int depth = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             parallel_valid,
   input  logic [width-1:0] parallel_data,
   output logic             parallel_ready,
   input  logic             serial_ready,
   output logic             serial_valid,
   output logic             serial_data,
   output logic             busy
);

   localparam int cw = $clog2(width);
   localparam int aw = $clog2(depth);

   logic [width-1:0] mem_r [depth];
   logic [aw-1:0]    rd_ptr_r;
   logic [aw-1:0]    wr_ptr_r;
   logic [aw:0]      count_r;
   logic [width-1:0] sh_data_r;
   logic [cw-1:0]    sh_cnt_r;
   logic             sh_valid_r;
   logic             ready_r;
   logic             busy_r;

   logic             push_s;
   logic             xfer_s;
   logic             last_bit_s;
   logic             fifo_empty_s;
   logic             load_s;
   logic             bypass_s;
   logic             pop_s;
   logic             wr_s;
   logic [width-1:0] load_word_s;
   logic [width-1:0] sh_data_next_s;
   logic [cw-1:0]    sh_cnt_next_s;
   logic             valid_next_s;
   logic [aw:0]      count_next_s;
   logic [aw+1:0]    occ_next_s;

   // Handshake decode, shifter next-state and occupancy (words in FIFO plus shifter)
   always_comb begin
      push_s         = parallel_valid & ready_r;
      xfer_s         = sh_valid_r & serial_ready;
      last_bit_s     = xfer_s & (sh_cnt_r == cw'(width - 1));
      fifo_empty_s   = (count_r == {(aw+1){1'b0}});
      // A word loads when the shifter is empty or finishing, from the FIFO head or straight from the input
      load_s         = (~sh_valid_r | last_bit_s) & (~fifo_empty_s | push_s);
      bypass_s       = load_s & fifo_empty_s;
      pop_s          = load_s & ~fifo_empty_s;
      wr_s           = push_s & ~bypass_s;
      load_word_s    = fifo_empty_s ? parallel_data : mem_r[rd_ptr_r];
      valid_next_s   = load_s | (sh_valid_r & ~last_bit_s);
      sh_data_next_s = load_s ? load_word_s :
                       (last_bit_s ? {width{1'b0}} :
                       (xfer_s ? (sh_data_r >> 1) : sh_data_r));
      sh_cnt_next_s  = load_s ? {cw{1'b0}} :
                       (xfer_s ? (sh_cnt_r + cw'(1)) : sh_cnt_r);
      count_next_s   = count_r + (aw+1)'(wr_s) - (aw+1)'(pop_s);
      occ_next_s     = (aw+2)'(count_next_s) + (aw+2)'(valid_next_s);
   end

   // FIFO storage; contents need no reset since count_r gates every read
   always_ff @(posedge clk) begin
      if (wr_s) begin
         mem_r[wr_ptr_r] <= parallel_data;
      end
   end

   // Pointers, shifter state and registered outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_ptr_r   <= {aw{1'b0}};
         wr_ptr_r   <= {aw{1'b0}};
         count_r    <= {(aw+1){1'b0}};
         sh_data_r  <= {width{1'b0}};
         sh_cnt_r   <= {cw{1'b0}};
         sh_valid_r <= 1'b0;
         ready_r    <= 1'b0;
         busy_r     <= 1'b0;
      end else begin
         if (wr_s) begin
            wr_ptr_r <= wr_ptr_r + aw'(1);
         end
         if (pop_s) begin
            rd_ptr_r <= rd_ptr_r + aw'(1);
         end
         count_r    <= count_next_s;
         sh_data_r  <= sh_data_next_s;
         sh_cnt_r   <= sh_cnt_next_s;
         sh_valid_r <= valid_next_s;
         ready_r    <= (occ_next_s < (aw+2)'(depth));
         busy_r     <= (count_next_s != {(aw+1){1'b0}}) | valid_next_s;
      end
   end

   // sh_data_r is cleared whenever the shifter empties, so bit 0 is 0 while invalid
   assign parallel_ready = ready_r;
   assign serial_valid   = sh_valid_r;
   assign serial_data    = sh_data_r[0];
   assign busy           = busy_r;

endmodule

// File: tb/tb_parallel_to_serial.sv
// Self-checking bench: two instances (depth 2 and depth 4) compared every cycle
// against a pending-bit queue model, plus literal expectations for directed cases.
module tb_parallel_to_serial;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       pv = 1'b0;
   logic       pv4 = 1'b0;
   logic [7:0] pd = 8'h00;
   logic       sr = 1'b0;
   logic       r0, v0, d0, b0;
   logic       r4, v4, d4, b4;

   int passed = 0;
   int total = 0;

   // model: per instance, bits not yet transferred, in output order
   bit  mbit [2][1024];
   int  hd [2];
   int  tl [2];
   bit  mready [2];
   int  mdepth [2];

   bit  obs0 [$];
   bit  obs4 [$];
   logic [7:0] acc0 [$];
   logic [7:0] acc4 [$];
   int  vcnt;
   int  cyc;
   int  vfirst;
   int  vlast;
   bit  saw_low;

   parallel_to_serial #(.width(8), .depth(2)) u0 (
      .clk(clk), .rst_n(rst_n), .parallel_valid(pv), .parallel_data(pd),
      .parallel_ready(r0), .serial_ready(sr), .serial_valid(v0),
      .serial_data(d0), .busy(b0));

   parallel_to_serial #(.width(8), .depth(4)) u4 (
      .clk(clk), .rst_n(rst_n), .parallel_valid(pv4), .parallel_data(pd),
      .parallel_ready(r4), .serial_ready(sr), .serial_valid(v4),
      .serial_data(d4), .busy(b4));

   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int exp);
      total++;
      if (act == exp) passed++;
      else $display("FAIL %s: got %0d expected %0d", name, act, exp);
   endtask

   task automatic model_clear();
      for (int i = 0; i < 2; i++) begin
         hd[i] = 0; tl[i] = 0; mready[i] = 1'b0;
      end
   endtask

   task automatic model_step();
      bit p [2];
      p[0] = pv; p[1] = pv4;
      for (int i = 0; i < 2; i++) begin
         bit acc;
         int words;
         acc = p[i] & mready[i];
         if ((tl[i] - hd[i]) > 0 && sr) hd[i]++;
         if (acc) begin
            for (int b = 0; b < 8; b++) begin
               mbit[i][tl[i] % 1024] = pd[b];
               tl[i]++;
            end
         end
         words = (tl[i] - hd[i] + 7) / 8;
         mready[i] = (words < mdepth[i]);
      end
   endtask

   task automatic compare_all();
      logic [3:0] act [2];
      act[0] = {r0, v0, d0, b0};
      act[1] = {r4, v4, d4, b4};
      for (int i = 0; i < 2; i++) begin
         int  n;
         bit  ed;
         n  = tl[i] - hd[i];
         ed = (n > 0) ? mbit[i][hd[i] % 1024] : 1'b0;
         chk($sformatf("parallel_ready[%0d]", i), int'(act[i][3]), int'(mready[i]));
         chk($sformatf("serial_valid[%0d]", i), int'(act[i][2]), int'(n > 0));
         chk($sformatf("serial_data[%0d]", i), int'(act[i][1]), int'(ed));
         chk($sformatf("busy[%0d]", i), int'(act[i][0]), int'(n > 0));
      end
   endtask

   task automatic cycle(input logic p, input logic p4, input logic [7:0] d, input logic s);
      pv = p; pv4 = p4; pd = d; sr = s;
      if (v0 && s) obs0.push_back(d0);
      if (v4 && s) obs4.push_back(d4);
      if (p && r0) acc0.push_back(d);
      if (p4 && r4) acc4.push_back(d);
      if (v0) begin
         vcnt++;
         if (vfirst < 0) vfirst = cyc;
         vlast = cyc;
      end
      if (!r0) saw_low = 1'b1;
      cyc++;
      @(posedge clk);
      model_step();
      @(negedge clk);
      compare_all();
   endtask

   task automatic push_hold(input logic [7:0] d, input bit rnd_sr);
      int n;
      n = 0;
      while (!r0 && n < 200) begin
         cycle(1'b1, 1'b0, d, rnd_sr ? 1'($urandom_range(0, 1)) : 1'b1);
         n++;
      end
      if (n >= 200) chk("push_timeout", 0, 1);
      else cycle(1'b1, 1'b0, d, rnd_sr ? 1'($urandom_range(0, 1)) : 1'b1);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      #1;
      model_clear();
      compare_all();
      @(negedge clk);
      compare_all();
      rst_n = 1'b1;
      cycle(1'b0, 1'b0, 8'h00, 1'b0);
   endtask

   task automatic check_bits(input string name, input logic [7:0] w);
      chk({name, "_count"}, obs0.size(), 8);
      for (int b = 0; b < 8 && b < obs0.size(); b++)
         chk($sformatf("%s_bit%0d", name, b), int'(obs0[b]), int'(w[b]));
   endtask

   task automatic check_words(input string name, input bit src4);
      int nw;
      nw = src4 ? acc4.size() : acc0.size();
      chk({name, "_bits"}, src4 ? obs4.size() : obs0.size(), nw * 8);
      for (int k = 0; k < nw; k++) begin
         logic [7:0] w;
         for (int b = 0; b < 8; b++)
            w[b] = src4 ? ((8*k+b < obs4.size()) ? obs4[8*k+b] : 1'b0)
                        : ((8*k+b < obs0.size()) ? obs0[8*k+b] : 1'b0);
         chk($sformatf("%s_word%0d", name, k), int'(w), src4 ? int'(acc4[k]) : int'(acc0[k]));
      end
   endtask

   initial begin
      int acc_cnt;
      mdepth[0] = 2; mdepth[1] = 4;
      model_clear();
      vfirst = -1; cyc = 0;
      @(negedge clk);
      do_reset();
      chk("ready_after_reset", int'(r0), 1);

      // 1: single word A5
      obs0.delete(); vcnt = 0;
      cycle(1'b1, 1'b0, 8'hA5, 1'b1);
      for (int k = 0; k < 10; k++) cycle(1'b0, 1'b0, 8'h00, 1'b1);
      check_bits("a5", 8'hA5);
      chk("a5_valid_cycles", vcnt, 8);
      chk("a5_busy_end", int'(b0), 0);

      // 2: three words back-to-back, no bubble
      obs0.delete(); acc0.delete(); vcnt = 0; vfirst = -1; saw_low = 1'b0;
      push_hold(8'h01, 1'b0);
      push_hold(8'hFF, 1'b0);
      push_hold(8'h80, 1'b0);
      for (int k = 0; k < 30; k++) cycle(1'b0, 1'b0, 8'h00, 1'b1);
      chk("stream_valid_cycles", vcnt, 24);
      chk("stream_no_bubble", vlast - vfirst + 1, 24);
      chk("stream_ready_dropped", int'(saw_low), 1);
      chk("stream_ready_back", int'(r0), 1);
      check_words("stream", 1'b0);

      // 3: 3C under stalls
      obs0.delete();
      cycle(1'b1, 1'b0, 8'h3C, 1'b0);
      for (int k = 0; k < 20; k++)
         cycle(1'b0, 1'b0, 8'h00, ((k % 4) == 0) || ((k % 4) == 3));
      check_bits("stall", 8'h3C);

      // 5: reset mid-word with words queued in both instances
      cycle(1'b1, 1'b1, 8'hC3, 1'b0);
      cycle(1'b1, 1'b1, 8'h11, 1'b0);
      cycle(1'b0, 1'b1, 8'h22, 1'b0);
      for (int k = 0; k < 3; k++) cycle(1'b0, 1'b0, 8'h00, 1'b1);
      rst_n = 1'b0;
      #1;
      chk("rst_valid", int'(v0), 0);
      chk("rst_busy", int'(b0), 0);
      chk("rst_ready", int'(r0), 0);
      chk("rst_busy4", int'(b4), 0);
      model_clear();
      @(negedge clk);
      rst_n = 1'b1;
      cycle(1'b0, 1'b0, 8'h00, 1'b0);
      obs0.delete(); obs4.delete();
      cycle(1'b1, 1'b0, 8'h5A, 1'b1);
      for (int k = 0; k < 12; k++) cycle(1'b0, 1'b0, 8'h00, 1'b1);
      check_bits("after_rst", 8'h5A);
      chk("after_rst_busy4", int'(b4), 0);

      // 6: depth 4 capacity under full backpressure
      obs4.delete(); acc4.delete();
      for (int k = 0; k < 5; k++) cycle(1'b0, 1'b1, 8'(8'h31 + 8'(k)), 1'b0);
      acc_cnt = acc4.size();
      chk("cap4_accepted", acc_cnt, 4);
      chk("cap4_ready_low", int'(r4), 0);
      for (int k = 0; k < 40; k++) cycle(1'b0, 1'b0, 8'h00, 1'b1);
      check_words("cap4", 1'b1);
      if (acc_cnt == 4) chk("cap4_first", int'(acc4[0]), 32'h31);

      // 4: random words, random backpressure, reassembled in order
      obs0.delete(); acc0.delete();
      for (int w = 0; w < 100; w++) begin
         push_hold(8'($urandom_range(0, 255)), 1'b1);
         for (int g = $urandom_range(0, 2); g > 0; g--)
            cycle(1'b0, 1'b0, 8'h00, 1'($urandom_range(0, 1)));
      end
      for (int k = 0; k < 400 && (v0 || b0); k++)
         cycle(1'b0, 1'b0, 8'h00, 1'($urandom_range(0, 1)));
      chk("rand_word_count", acc0.size(), 100);
      check_words("rand", 1'b0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
